// File: rtl/mac_pkg.sv
// Shared types for the mac operand path: float16 layout, feeder FIFO entry, issue FSM states.
package mac_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } float16_t;

  localparam logic [4:0] FP16_EXP_SPECIAL = 5'h1F;

  typedef enum logic {
    START = 1'b0,
    RUN   = 1'b1
  } feeder_state_t;

  // One buffered beat; {last, b, a} is 33 bits.
  typedef struct packed {
    logic     last;
    float16_t b;
    float16_t a;
  } feeder_entry_t;

  // Inf or NaN: all-ones exponent.
  function automatic logic is_special(input float16_t x);
    return x.exp == FP16_EXP_SPECIAL;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy is tracked explicitly and decides full/empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [WIDTH-1:0]         WR_DATA,
  input  logic                     RD_EN,
  output logic [WIDTH-1:0]         RD_DATA,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [$clog2(DEPTH):0]   LEVEL_NXT,
  output logic                     FULL,
  output logic                     EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign FULL    = (LEVEL == LW'(DEPTH));
  assign EMPTY   = (LEVEL == '0);
  assign wr_ok   = WR_EN & ~FULL;
  assign rd_ok   = RD_EN & ~EMPTY;
  assign RD_DATA = mem[rd_ptr];

  always_comb begin
    LEVEL_NXT = LEVEL;
    if (wr_ok && !rd_ok)      LEVEL_NXT = LEVEL + 1'b1;
    else if (!wr_ok && rd_ok) LEVEL_NXT = LEVEL - 1'b1;
  end

  // Storage is not reset; a cleared LEVEL makes stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      LEVEL <= LEVEL_NXT;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Operand-issue stage for mac: buffers operand beats, drives DVI/DI/RELEASE,
// flags Inf/NaN operands and counts fully issued vectors.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     S_VALID,
  output logic                     S_READY,
  input  logic [15:0]              S_A,
  input  logic [15:0]              S_B,
  input  logic                     S_LAST,
  input  logic                     EN,
  output logic                     DVI,
  output logic [31:0]              DI,
  output logic                     RELEASE,
  output logic                     ERR_SPECIAL,
  input  logic                     ERR_CLR,
  output logic [CNT_W-1:0]         VEC_CNT,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(feeder_entry_t);

  feeder_entry_t  wr_entry, rd_entry;
  logic [EW-1:0]  rd_data;
  logic [LW-1:0]  level_nxt;
  logic           full, empty;
  logic           wr, pop;
  feeder_state_t  state;

  assign wr       = S_VALID & S_READY;
  assign pop      = EN & ~empty;
  assign wr_entry = '{last: S_LAST, b: float16_t'(S_B), a: float16_t'(S_A)};
  assign rd_entry = feeder_entry_t'(rd_data);

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (wr),
    .WR_DATA   (wr_entry),
    .RD_EN     (pop),
    .RD_DATA   (rd_data),
    .LEVEL     (LEVEL),
    .LEVEL_NXT (level_nxt),
    .FULL      (full),
    .EMPTY     (empty)
  );

  // Issue FSM with registered mac-side outputs; idle cycles drive zero data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= START;
      S_READY     <= 1'b0;
      DVI         <= 1'b0;
      DI          <= '0;
      RELEASE     <= 1'b0;
      ERR_SPECIAL <= 1'b0;
      VEC_CNT     <= '0;
    end else begin
      // Ready looks at next occupancy so it never waits on S_VALID.
      S_READY <= (level_nxt != LW'(DEPTH));
      DVI     <= pop;
      DI      <= pop ? {rd_entry.b, rd_entry.a} : '0;
      RELEASE <= pop && (state == START);
      if (pop) begin
        state <= rd_entry.last ? START : RUN;
        if (rd_entry.last) VEC_CNT <= VEC_CNT + 1'b1;
      end
      // Set dominates a simultaneous clear.
      if (pop && (is_special(rd_entry.a) || is_special(rd_entry.b)))
        ERR_SPECIAL <= 1'b1;
      else if (ERR_CLR)
        ERR_SPECIAL <= 1'b0;
    end
  end

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Operand-issue stage directly upstream of `mac`. It accepts float16 operand pairs on a valid/ready stream with a last-element marker and buffers them in a small FIFO. It drives `mac`'s `DVI`/`DI`/`RELEASE` so that each vector's first element restarts accumulation. It also flags special (Inf/NaN) operands and counts issued vectors for the controller of the systolic array.

## Interface

Parameters:
- `DEPTH`, 8: FIFO depth in entries; must be a power of two, at least 2.
- `CNT_W`, 16: width of the vector counter.

Ports (clock and reset first):
- `CLK`  in  1: clock; all logic is on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `S_VALID`  in  1: upstream beat valid.
- `S_READY`  out  1: feeder can accept a beat.
- `S_A`  in  16: operand A, float16.
- `S_B`  in  16: operand B, float16.
- `S_LAST`  in  1: beat is the last element of a dot-product vector.
- `EN`  in  1: issue enable; while low, nothing is popped and the FIFO keeps filling.
- `DVI`  out  1: to `mac.DVI`.
- `DI`  out  32: to `mac.DI`, driven as `{B, A}`.
- `RELEASE`  out  1: to `mac.RELEASE`; high with the first element of each vector.
- `ERR_SPECIAL`  out  1: sticky flag, set when an issued operand has exponent 5'b11111.
- `ERR_CLR`  in  1: clears `ERR_SPECIAL`.
- `VEC_CNT`  out  CNT_W: number of vectors fully issued; wraps modulo 2^CNT_W.
- `LEVEL`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation

- FIFO entry holds `{LAST, B, A}` (33 bits). A write occurs when `S_VALID & S_READY`.
- `S_READY = (LEVEL != DEPTH)`. It is registered from the next-state occupancy, so it never depends combinationally on `S_VALID`.
- A pop occurs when `EN & (LEVEL != 0)`. A popped entry drives the registered `DVI=1`, `DI={B,A}` and `RELEASE=first` in the next cycle. With no pop, `DVI=0`, `DI=0` and `RELEASE=0`; zeroed idle data matches the `mac` bench convention.
- Issue FSM, two states:
  - START: the next issued element carries `RELEASE=1`.
    - Issuing an element with LAST=1 stays in START and increments `VEC_CNT`.
    - Issuing an element with LAST=0 goes to RUN.
  - RUN: elements issue with `RELEASE=0`.
    - Issuing an element with LAST=1 goes to START and increments `VEC_CNT`.
  - A single-element vector therefore issues with `RELEASE=1` and increments `VEC_CNT` once.
- `ERR_SPECIAL` is set in the cycle after issuing an element where `A[14:10]==5'h1F` or `B[14:10]==5'h1F`. The element is still forwarded unchanged; `mac` reports it through `DO_TYPE`.
  - `ERR_CLR` clears the flag.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous write and pop leave `LEVEL` unchanged. There is no bypass: an empty FIFO is never read in the cycle it is written.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are decided by `LEVEL`, not by pointer equality.

## Timing

- Reset:
  - Occupancy and pointers go to 0; FIFO contents are discarded.
  - FSM goes to START.
  - Reset values: `S_READY=0` during reset, 1 in the first cycle after `RST` deasserts. `DVI=0`, `DI=0`, `RELEASE=0`, `ERR_SPECIAL=0`, `VEC_CNT=0`, `LEVEL=0`.
- Reset asserted mid-vector drops the partial vector. The first element issued after reset carries `RELEASE=1`.
- Latency:
  - A beat accepted at edge k is popped at edge k+1 at the earliest. `DVI` is high in the cycle following edge k+1, i.e. 2 cycles accept-to-issue.
  - `VEC_CNT` updates at the same edge as the issue of the LAST element.
- Throughput is one element per cycle sustained when `EN=1` and upstream streams continuously; occupancy stays ≤1.
- While `EN=0`, outputs hold `DVI=0`. The FSM state, counter and flag are frozen, apart from `ERR_CLR`.
- While full, `S_READY=0`. A pop at edge k makes `S_READY=1` in the cycle after edge k.

## Structure

- Shared package `mac_pkg`:
  - `float16_t` packed struct (sign, exp[4:0], frac[9:0]).
  - Constant `FP16_EXP_SPECIAL = 5'h1F`.
  - Enum `feeder_state_t` {START, RUN}.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH): write/read enables, `LEVEL`, full/empty, synchronous active-high `RST`. The issue FSM, flag and counter live in `mac_feeder`.

## Test plan

- Reset then single vector: beats A=0x3C00, B=0x4000, then A=0x3800, B=0x3800 with LAST. Expect two `DVI` pulses starting 2 cycles after the first accept, `DI` 0x40003C00 with `RELEASE=1`, then 0x38003800 with `RELEASE=0`, and `VEC_CNT`=1.
- Back-to-back single-element vectors (LAST=1 every beat, 4 beats): expect `RELEASE=1` on all 4 issues and `VEC_CNT`=4.
- `EN=0`, stream 9 beats with DEPTH=8: expect `S_READY` low after 8 accepts and `LEVEL`=8. Raise `EN`: 8 consecutive `DVI` pulses in order, then the 9th beat follows.
- Special operand: A=0x7C00 mid-vector. Expect the element forwarded unchanged and `ERR_SPECIAL`=1. Pulse `ERR_CLR`: expect 0 the next cycle. `ERR_CLR` together with another special operand: the flag stays 1.
- `RST` pulse mid-vector with 3 entries buffered: expect `LEVEL`=0 and no `DVI` after reset. The next vector's first element issues with `RELEASE=1`.
- Counter wrap with CNT_W=2: 5 single-element vectors, expect `VEC_CNT`=1.
